// File: rtl/svm_arbiter_pkg.sv
// Shared types and defaults for the SVM feature-stream arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package svm_arbiter_pkg;

    // Controller states; IDLE must stay the reset encoding.
    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        WAIT_RES,
        EMIT,
        CLEAR
    } state_t;

    localparam int DATA_W            = 128;
    localparam int BEATS_PER_VEC_DEF = 512;
    localparam int RES_TIMEOUT_DEF   = 4096;

    // Index width that stays legal for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/svm_arbiter_rr_pick.sv
// Round-robin picker: first asserted request strictly after 'last', wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample the grant.
module rr_pick
    import svm_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = id_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] grant,
    output logic         any
);

    // Walk candidates from farthest to nearest so the nearest hit after 'last' wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (((req >> ((int'(last) + k) % N)) & N'(1)) != '0) begin
                grant = W'((int'(last) + k) % N);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/svm_arbiter.sv
// Grants one requester FIFO at a time to the classifier engine for a full vector, then returns its result.
// Latency: grant one cycle after a requester is seen non-empty; beats pass combinationally from FIFO to engine.
// Backpressure: engine pops pace the stream; requester underflow stalls it; result is held until res_ready.
module svm_arbiter
    import svm_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int BEATS_PER_VEC = BEATS_PER_VEC_DEF,
    parameter int RES_TIMEOUT   = RES_TIMEOUT_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_empty,
    input  logic [DATA_W*NUM_REQ-1:0]      req_data,
    output logic [NUM_REQ-1:0]             req_rd,
    output logic [DATA_W-1:0]              eng_rd_data,
    output logic                           eng_rd_empty,
    input  logic                           eng_rd_fifo,
    input  logic                           eng_type,
    input  logic                           eng_type_ready,
    output logic                           eng_clr,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [id_width(NUM_REQ)-1:0]   res_id,
    output logic                           res_label,
    output logic                           res_err,
    output logic                           busy
);

    localparam int IDW = id_width(NUM_REQ);
    localparam int BCW = $clog2(BEATS_PER_VEC + 1);
    localparam int TCW = $clog2(RES_TIMEOUT + 1);

    state_t         state;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] last_grant;
    logic [BCW-1:0] beat_cnt;
    logic [TCW-1:0] tmo_cnt;
    logic           clr_q;

    logic [IDW-1:0] pick;
    logic           pick_any;
    logic           sel_empty;
    logic           vec_done;
    logic           stream_on;
    logic           pop;

    rr_pick #(
        .N (NUM_REQ),
        .W (IDW)
    ) u_rr_pick (
        .req   (~req_empty),
        .last  (last_grant),
        .grant (pick),
        .any   (pick_any)
    );

    // Zero-latency data/empty path from the granted FIFO; reset closes the path immediately.
    always_comb begin
        sel_empty    = ((req_empty >> grant) & NUM_REQ'(1)) != '0;
        vec_done     = (beat_cnt == BCW'(BEATS_PER_VEC));
        stream_on    = (state == STREAM) && !reset;
        eng_rd_empty = !stream_on || sel_empty || vec_done;
        pop          = eng_rd_fifo && !eng_rd_empty;
        req_rd       = pop ? (NUM_REQ'(1) << grant) : '0;
        eng_rd_data  = DATA_W'(req_data >> (DATA_W * int'(grant)));
        eng_clr      = clr_q || reset;
        busy         = (state != IDLE);
    end

    // Vector controller: grant, count beats, wait for the label, emit, clear the engine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
            beat_cnt   <= '0;
            tmo_cnt    <= '0;
            clr_q      <= 1'b0;
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_label  <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (pop) begin
                        beat_cnt <= beat_cnt + BCW'(1);
                        if (beat_cnt == BCW'(BEATS_PER_VEC - 1)) begin
                            tmo_cnt <= '0;
                            state   <= WAIT_RES;
                        end
                    end
                end
                WAIT_RES: begin
                    if (eng_type_ready) begin
                        res_label <= eng_type;
                        res_err   <= 1'b0;
                        res_id    <= grant;
                        res_valid <= 1'b1;
                        state     <= EMIT;
                    end else if (tmo_cnt == TCW'(RES_TIMEOUT - 1)) begin
                        res_label <= 1'b0;
                        res_err   <= 1'b1;
                        res_id    <= grant;
                        res_valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TCW'(1);
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        clr_q     <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    clr_q      <= 1'b0;
                    last_grant <= grant;
                    beat_cnt   <= '0;
                    tmo_cnt    <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
